// File: rtl/pe_arb_pkg.sv
// Shared types and helpers for the pe_arb_ctrl grant controller.
// Optional round-robin selection is enabled with macro PE_ARB_ROUND_ROBIN_EN.
package pe_arb_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Binary index of the set bit in a one-hot vector (up to 8 requesters).
    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pe_arb_pick.sv
// Combinational winner selection: searches the unmasked request vector
// downward from a start index with wrap-around; the first set bit wins.
module pe_arb_pick
    import pe_arb_pkg::*;
#(
    parameter int unsigned N   = 3,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_mask,
    input  logic [IDW-1:0] i_start,
    output logic [N-1:0]   o_win,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    logic [N-1:0] w_masked;
    logic [N-1:0] w_win;
    int unsigned  w_best_d;
    int unsigned  w_d;

    assign w_masked = i_req & ~i_mask;

    // Winner is the candidate with the smallest downward distance from i_start.
    always_comb begin
        w_win    = '0;
        w_best_d = N;
        w_d      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_d = (int'(i_start) + N - i) % N;
            if (w_masked[i] && (w_d < w_best_d)) begin
                w_best_d = w_d;
                w_win    = '0;
                w_win[i] = 1'b1;
            end
        end
    end

    assign o_win = w_win;
    assign o_idx = IDW'(oh2idx(8'(w_win)));
    assign o_any = |w_masked;

endmodule

// File: rtl/pe_arb_ctrl.sv
// Grant controller sharing one resource among N requesters: registered
// one-hot grant, bounded hold with preemption and a one-cycle turnaround gap.
// Define PE_ARB_ROUND_ROBIN_EN for rotating selection; default is fixed
// priority with the highest index winning.
module pe_arb_ctrl
    import pe_arb_pkg::*;
#(
    parameter int unsigned N        = 3,
    parameter int unsigned IDW      = 2,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HCW      = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_vld,
    output logic           preempt
);

    state_t         r_state;
    logic [HCW-1:0] r_hold;
    logic [N-1:0]   r_mask;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic           r_gnt_vld;
    logic           r_preempt;

    logic [N-1:0]   w_win;
    logic [IDW-1:0] w_idx;
    logic           w_any;
    logic [IDW-1:0] w_start;
    logic           w_owner_req;
    logic           w_others_req;
    logic           w_timeout;

`ifdef PE_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] r_rr_ptr;
    assign w_start = r_rr_ptr;
`else
    assign w_start = IDW'(N - 1);
`endif

    pe_arb_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .i_req   (req),
        .i_mask  (r_mask),
        .i_start (w_start),
        .o_win   (w_win),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Owner is tracked by the registered one-hot grant, so no index decode is needed.
    assign w_owner_req  = |(req & r_gnt);
    assign w_others_req = |(req & ~r_gnt);
    assign w_timeout    = (MAX_HOLD != 0) && (r_hold == HCW'(MAX_HOLD));

    // Grant FSM with registered outputs, hold counter and one-shot mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            r_mask    <= '0;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_gnt_vld <= 1'b0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state   <= GRANT;
                        r_gnt     <= w_win;
                        r_gnt_id  <= w_idx;
                        r_gnt_vld <= 1'b1;
                        r_hold    <= HCW'(1);
                        r_mask    <= '0;
                    end else if (|req) begin
                        r_mask <= '0;
                    end
                end
                GRANT: begin
                    if (!w_owner_req || w_timeout) begin
                        r_state   <= GAP;
                        r_gnt     <= '0;
                        r_gnt_id  <= '0;
                        r_gnt_vld <= 1'b0;
                        r_hold    <= '0;
                        // Release wins over timeout: preempt and mask only for a live owner.
                        if (w_owner_req) begin
                            r_preempt <= 1'b1;
                            r_mask    <= w_others_req ? r_gnt : '0;
                        end else begin
                            r_mask <= '0;
                        end
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef PE_ARB_ROUND_ROBIN_EN
    // Rotate the search start to just below the most recent winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= IDW'(N - 1);
        end else if ((r_state == IDLE) && w_any) begin
            r_rr_ptr <= (w_idx == '0) ? IDW'(N - 1) : (w_idx - 1'b1);
        end
    end
`endif

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = r_gnt_vld;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_pe_arb_ctrl.sv
// Self-checking bench for pe_arb_ctrl: directed scenarios followed by
// randomized request traffic, all checked against a transaction-level model.
module tb_pe_arb_ctrl;

    localparam int unsigned N        = 3;
    localparam int unsigned IDW      = 2;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned HCW      = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_vld;
    logic           preempt;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: owner index (-1 = nobody), cycles held, one-shot
    // exclusion set, a pending turnaround cycle, and the search start.
    int           m_owner;
    int           m_held;
    logic [N-1:0] m_mask;
    bit           m_cooldown;
    int           m_ptr;
    bit           m_pre;

    pe_arb_ctrl #(
        .N        (N),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD),
        .HCW      (HCW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First eligible requester scanning downward from start, wrapping.
    function automatic int m_pick(input logic [N-1:0] r, input logic [N-1:0] msk, input int start);
        for (int k = 0; k < int'(N); k++) begin
            int i;
            i = (start - k + int'(N)) % int'(N);
            if (r[i] && !msk[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_rst, input logic [N-1:0] r);
        int w;
        logic [N-1:0] own;
        m_pre = 1'b0;
        if (r_rst) begin
            m_owner = -1; m_held = 0; m_mask = '0; m_cooldown = 1'b0; m_ptr = N - 1;
            return;
        end
        if (m_cooldown) begin
            m_cooldown = 1'b0;
        end else if (m_owner < 0) begin
`ifdef PE_ARB_ROUND_ROBIN_EN
            w = m_pick(r, m_mask, m_ptr);
`else
            w = m_pick(r, m_mask, N - 1);
`endif
            if (w >= 0) begin
                m_owner = w; m_held = 1; m_mask = '0;
                m_ptr = (w + int'(N) - 1) % int'(N);
            end else if (r != '0) begin
                m_mask = '0;
            end
        end else begin
            own = '0;
            own[m_owner] = 1'b1;
            if ((r & own) == '0) begin
                m_owner = -1; m_held = 0; m_mask = '0; m_cooldown = 1'b1;
            end else if (MAX_HOLD != 0 && m_held == int'(MAX_HOLD)) begin
                m_pre = 1'b1;
                m_mask = ((r & ~own) != '0) ? own : '0;
                m_owner = -1; m_held = 0; m_cooldown = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    // Drive inputs, clock once, advance the model, then compare away from the edge.
    task automatic cyc(input logic r_rst, input logic [N-1:0] r);
        logic [N-1:0] eg;
        rst = r_rst;
        req = r;
        @(posedge clk);
        model_step(r_rst, r);
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check_val("gnt",     32'(gnt),     32'(eg));
        check_val("gnt_id",  32'(gnt_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check_val("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
        check_val("preempt", 32'(preempt), 32'(m_pre));
    endtask

    logic [N-1:0] rq;

    initial begin
        m_owner = -1; m_held = 0; m_mask = '0; m_cooldown = 1'b0; m_ptr = N - 1; m_pre = 1'b0;
        rst = 1'b1;
        req = 3'b111;
        @(negedge clk);

        // Reset held with all requests high, then first grant after release.
        cyc(1'b1, 3'b111);
        cyc(1'b1, 3'b111);
        cyc(1'b0, 3'b111);
        check_val("first_grant_vld", 32'(gnt_vld), 32'd1);
        repeat (4) cyc(1'b0, 3'b000);

        // Single arbitration with release then lower requester.
        cyc(1'b0, 3'b011);
        cyc(1'b0, 3'b011);
        repeat (3) cyc(1'b0, 3'b001);
        check_val("single_next_owner", 32'(gnt), 32'h1);
        repeat (4) cyc(1'b0, 3'b000);

        // Fixed-priority contention: owner 2 drops after two cycles.
        cyc(1'b0, 3'b111);
        cyc(1'b0, 3'b111);
        repeat (3) cyc(1'b0, 3'b011);
        repeat (4) cyc(1'b0, 3'b000);

        // Hold timeout with two constant requesters.
        repeat (16) cyc(1'b0, 3'b101);
        repeat (4) cyc(1'b0, 3'b000);

        // Reset during the second grant cycle.
        cyc(1'b0, 3'b111);
        cyc(1'b0, 3'b111);
        cyc(1'b1, 3'b111);
        check_val("rst_mid_gnt", 32'(gnt), 32'h0);
        repeat (3) cyc(1'b0, 3'b111);
        repeat (4) cyc(1'b0, 3'b000);

        // Release coinciding with the hold limit must not flag preemption.
        repeat (MAX_HOLD) cyc(1'b0, 3'b100);
        cyc(1'b0, 3'b000);
        check_val("rel_tmo_preempt", 32'(preempt), 32'd0);
        repeat (3) cyc(1'b0, 3'b000);

        // Randomized traffic where requesters tend to hold their bit.
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < int'(N); b++) begin
                if (rq[b]) begin
                    if ($urandom_range(4, 0) == 0) rq[b] = 1'b0;
                end else begin
                    if ($urandom_range(2, 0) == 0) rq[b] = 1'b1;
                end
            end
            cyc(($urandom_range(99, 0) == 0), rq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pe_arb_ctrl.md
Name: pe_arb_ctrl

Overview:
- Grant controller that shares one downstream resource among N requesters using priority-encoder selection.
- Default mapping: t3 > t2 > t1 becomes req[2] > req[1] > req[0].
- Adds grant ownership, a bounded hold time with preemption, and a mandatory one-cycle turnaround gap.
- Sits between requester blocks and the shared resource's enable/select inputs.

Parameters:
N, 3, number of requesters (2..8)
IDW, 2, width of gnt_id; must equal ceil(log2(N))
MAX_HOLD, 4, max consecutive grant cycles per ownership; 0 = unlimited
HCW, 3, hold counter width; must hold MAX_HOLD

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  N  request vector; requester holds its bit high while it wants/uses the resource
gnt  output  N  one-hot grant, registered
gnt_id  output  IDW  binary index of granted requester, registered; 0 when gnt_vld=0
gnt_vld  output  1  high when gnt is nonzero
preempt  output  1  one-cycle pulse, registered, when a grant is ended by hold timeout

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: gnt=0, gnt_id=0, gnt_vld=0, preempt=0, state=IDLE, hold_cnt=0, mask=0, rr_ptr=N-1.
- Reset mid-grant: gnt drops at that edge, with no GAP cycle.
- States:
  - IDLE: if (req & ~mask) is nonzero, pick a winner and enter GRANT. gnt, gnt_id and gnt_vld assert at that same edge (1-cycle latency from sampled req). If the masked vector is zero but req is nonzero, clear mask and stay IDLE.
  - GRANT: hold_cnt increments each cycle, starting at 1 on the first grant cycle.
    - req[owner]=0 → GAP; clear mask.
    - req[owner]=1 and MAX_HOLD≠0 and hold_cnt==MAX_HOLD → GAP; pulse preempt; set mask = one-hot(owner) only if another req bit is high, else mask=0.
    - Release takes precedence over timeout in the same cycle (no preempt).
  - GAP: exactly one cycle with gnt=0, gnt_vld=0, gnt_id=0, hold_cnt=0; then IDLE.
- Worst-case turnaround from release to next grant: 3 edges (GRANT→GAP→IDLE→GRANT).
- Selection, fixed priority: highest set index wins.
- mask applies to exactly one arbitration, then clears.
- req changes from non-owners during GRANT are ignored.
- Owner ID is registered at grant entry and never changes during GRANT.

Optional Feature:
- Macro: PE_ARB_ROUND_ROBIN_EN.
- Defined:
  - Selection starts at rr_ptr and searches downward with wrap (rr_ptr, rr_ptr-1, …, 0, N-1, …).
  - On each grant entry, rr_ptr ← (winner-1) mod N.
  - mask is still honoured on top of this.
- Undefined: fixed priority as above; rr_ptr is absent from the RTL.

Decomposition:
- Package pe_arb_pkg: state enum (IDLE, GRANT, GAP), state width constant, one-hot-to-index function.
- Sub-module pe_arb_pick (combinational):
  - Inputs: req, mask, start index.
  - Outputs: one-hot winner, winner index, any_valid.
  - Instantiated once; start tied to N-1 when the round-robin macro is undefined.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req=3'b111 → gnt=000, gnt_id=0, gnt_vld=0, preempt=0 throughout, and on the first edge after rst deasserts the first grant appears.
2. Single arbitration: req=3'b011 from IDLE → next edge gnt=010, gnt_id=1, gnt_vld=1; drop req[1] → one GAP cycle gnt=000, then IDLE, then gnt=001.
3. Fixed priority contention: req=3'b111, owner 2 drops after 2 cycles → gnt=100 ×2, 000 (GAP), 000 (IDLE), then 010.
4. Timeout, MAX_HOLD=4: req=3'b101 held constant → gnt=100 for exactly 4 cycles, preempt=1 on GAP edge, then gnt=001 (2 masked) for 4 cycles, then gnt=100 again.
5. Round robin (PE_ARB_ROUND_ROBIN_EN, MAX_HOLD=1): req=3'b111 held → grant order 2,1,0,2,1, each separated by GAP+IDLE.
6. Reset mid-operation and edge cases:
   - rst=1 during 2nd GRANT cycle → gnt=000 next edge, rr_ptr=N-1.
   - Release and timeout in the same cycle → preempt stays 0.
